// File: rtl/load_store_unit_if.sv
// OCP-style data bus between the load/store unit (master) and the memory slave.
interface load_store_unit_if;
  logic [31:0] o_MAddr;
  logic [2:0]  o_MCmd;
  logic [31:0] o_MData;
  logic [3:0]  o_MByteEn;
  logic        i_SCmdAccept;
  logic [31:0] i_SData;
  logic [1:0]  i_SResp;

  modport master (
    output o_MAddr, o_MCmd, o_MData, o_MByteEn,
    input  i_SCmdAccept, i_SData, i_SResp
  );

  modport slave (
    input  o_MAddr, o_MCmd, o_MData, o_MByteEn,
    output i_SCmdAccept, i_SData, i_SResp
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding big-endian load/store unit driving an OCP-style data master port.
// Optional CPU_LSU_POSTED_WRITE_EN: stores complete on command accept without a response.
module load_store_unit (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [1:0]  lsu_cmd,
  input  logic        lsu_rnw,
  output logic [31:0] lsu_rdata,
  output logic        lsu_busy,
  output logic        lsu_err_align,
  output logic        lsu_err_bus,
  load_store_unit_if.master bus
);

  localparam logic [1:0] CmdIdle  = 2'b00;
  localparam logic [1:0] CmdByte  = 2'b01;
  localparam logic [1:0] CmdHword = 2'b10;
  localparam logic [1:0] CmdWord  = 2'b11;

  localparam logic [2:0] MCmdIdle = 3'b000;
  localparam logic [2:0] MCmdWr   = 3'b001;
  localparam logic [2:0] MCmdRd   = 3'b010;

  localparam logic [1:0] RespNull = 2'b00;
  localparam logic [1:0] RespDva  = 2'b01;
  localparam logic [1:0] RespErr  = 2'b11;

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        rnw_q, rnw_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] maddr_q, maddr_d;
  logic [2:0]  mcmd_q, mcmd_d;
  logic [31:0] mdata_q, mdata_d;
  logic [3:0]  mbe_q, mbe_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_align_q, err_align_d;
  logic        err_bus_q, err_bus_d;

  logic        aligned;
  logic [3:0]  new_be;
  logic [31:0] new_data;
  logic [31:0] rd_shifted;
  logic [31:0] rd_aligned;
  logic        posted_wr;

`ifdef CPU_LSU_POSTED_WRITE_EN
  assign posted_wr = 1'b1;
`else
  assign posted_wr = 1'b0;
`endif

  // Alignment and lane steering for the incoming command.
  always_comb begin
    aligned  = 1'b0;
    new_be   = 4'b1111;
    new_data = lsu_wdata;
    unique case (lsu_cmd)
      CmdIdle: aligned = 1'b0;
      CmdByte: begin
        aligned  = 1'b1;
        new_be   = 4'b1000 >> lsu_addr[1:0];
        new_data = {4{lsu_wdata[7:0]}};
      end
      CmdHword: begin
        aligned  = ~lsu_addr[0];
        new_be   = lsu_addr[1] ? 4'b0011 : 4'b1100;
        new_data = {2{lsu_wdata[15:0]}};
      end
      CmdWord: begin
        aligned  = (lsu_addr[1:0] == 2'b00);
        new_be   = 4'b1111;
        new_data = lsu_wdata;
      end
    endcase
    if (lsu_rnw) new_data = '0;
  end

  // Byte lane (3 - offset) sits at bit position 8 * ~offset in big-endian order.
  assign rd_shifted = bus.i_SData >> {~off_q, 3'b000};

  always_comb begin
    rd_aligned = bus.i_SData;
    unique case (op_q)
      CmdByte:  rd_aligned = {24'b0, rd_shifted[7:0]};
      CmdHword: rd_aligned = off_q[1] ? {16'b0, bus.i_SData[15:0]}
                                      : {16'b0, bus.i_SData[31:16]};
      CmdWord:  rd_aligned = bus.i_SData;
      CmdIdle:  rd_aligned = bus.i_SData;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rnw_d       = rnw_q;
    off_d       = off_q;
    maddr_d     = maddr_q;
    mcmd_d      = mcmd_q;
    mdata_d     = mdata_q;
    mbe_d       = mbe_q;
    rdata_d     = rdata_q;
    err_align_d = 1'b0;
    err_bus_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (lsu_cmd != CmdIdle) begin
          if (aligned) begin
            op_d    = lsu_cmd;
            rnw_d   = lsu_rnw;
            off_d   = lsu_addr[1:0];
            maddr_d = {lsu_addr[31:2], 2'b00};
            mcmd_d  = lsu_rnw ? MCmdRd : MCmdWr;
            mdata_d = new_data;
            mbe_d   = new_be;
            state_d = StReq;
          end else begin
            err_align_d = 1'b1;
          end
        end
      end
      StReq: begin
        if (bus.i_SCmdAccept) begin
          mcmd_d  = MCmdIdle;
          state_d = (posted_wr && !rnw_q) ? StIdle : StResp;
        end
      end
      StResp: begin
        if (bus.i_SResp == RespDva) begin
          if (rnw_q) rdata_d = rd_aligned;
          state_d = StIdle;
        end else if (bus.i_SResp == RespErr) begin
          err_bus_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= StIdle;
      op_q        <= CmdIdle;
      rnw_q       <= 1'b0;
      off_q       <= 2'b00;
      maddr_q     <= '0;
      mcmd_q      <= MCmdIdle;
      mdata_q     <= '0;
      mbe_q       <= '0;
      rdata_q     <= '0;
      err_align_q <= 1'b0;
      err_bus_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rnw_q       <= rnw_d;
      off_q       <= off_d;
      maddr_q     <= maddr_d;
      mcmd_q      <= mcmd_d;
      mdata_q     <= mdata_d;
      mbe_q       <= mbe_d;
      rdata_q     <= rdata_d;
      err_align_q <= err_align_d;
      err_bus_q   <= err_bus_d;
    end
  end

  assign lsu_busy      = (state_q != StIdle) || ((lsu_cmd != CmdIdle) && aligned);
  assign lsu_rdata     = rdata_q;
  assign lsu_err_align = err_align_q;
  assign lsu_err_bus   = err_bus_q;

  assign bus.o_MAddr   = maddr_q;
  assign bus.o_MCmd    = mcmd_q;
  assign bus.o_MData   = mdata_q;
  assign bus.o_MByteEn = mbe_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: lane steering, alignment errors, wait states, bus errors,
// reset mid-transaction. Store busy length follows CPU_LSU_POSTED_WRITE_EN.
module tb_load_store_unit;

  localparam logic [1:0] CmdIdle  = 2'b00;
  localparam logic [1:0] CmdByte  = 2'b01;
  localparam logic [1:0] CmdHword = 2'b10;
  localparam logic [1:0] CmdWord  = 2'b11;
  localparam logic [1:0] RespNull = 2'b00;
  localparam logic [1:0] RespDva  = 2'b01;
  localparam logic [1:0] RespErr  = 2'b11;

`ifdef CPU_LSU_POSTED_WRITE_EN
  localparam bit Posted = 1'b1;
`else
  localparam bit Posted = 1'b0;
`endif
  localparam int WrBusy = Posted ? 2 : 3;

  logic        clk;
  logic        nrst;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [1:0]  lsu_cmd;
  logic        lsu_rnw;
  logic [31:0] lsu_rdata;
  logic        lsu_busy;
  logic        lsu_err_align;
  logic        lsu_err_bus;

  int n_checks;
  int n_fail;

  load_store_unit_if bus_if ();

  load_store_unit dut (
    .clk           (clk),
    .nrst          (nrst),
    .lsu_addr      (lsu_addr),
    .lsu_wdata     (lsu_wdata),
    .lsu_cmd       (lsu_cmd),
    .lsu_rnw       (lsu_rnw),
    .lsu_rdata     (lsu_rdata),
    .lsu_busy      (lsu_busy),
    .lsu_err_align (lsu_err_align),
    .lsu_err_bus   (lsu_err_bus),
    .bus           (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_mcmd"}, 32'(bus_if.o_MCmd), 32'd0);
    check_eq({tag, "_busy"}, 32'(lsu_busy), 32'd0);
    check_eq({tag, "_ealign"}, 32'(lsu_err_align), 32'd0);
    check_eq({tag, "_ebus"}, 32'(lsu_err_bus), 32'd0);
  endtask

  // One aligned command: acc_wait REQ wait states, nulls RESP wait states, then resp.
  task automatic run_op(input string tag, input logic [1:0] cmd, input logic rnw,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int acc_wait, input int nulls, input logic [1:0] resp,
                        input logic [31:0] sdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_mdata, input logic [31:0] exp_rdata,
                        input int exp_busy);
    int  busy_n;
    bit  skip_resp;
    busy_n    = 0;
    skip_resp = Posted && !rnw;
    @(posedge clk); #1;
    lsu_cmd = cmd; lsu_rnw = rnw; lsu_addr = addr; lsu_wdata = wdata;
    @(negedge clk);
    if (lsu_busy) busy_n++;
    @(posedge clk); #1;
    lsu_cmd = CmdIdle;
    for (int n = 0; n <= acc_wait; n++) begin
      bus_if.i_SCmdAccept = (n == acc_wait);
      bus_if.i_SResp      = RespErr;  // must be ignored while in REQ
      @(negedge clk);
      if (lsu_busy) busy_n++;
      check_eq({tag, "_mcmd"}, 32'(bus_if.o_MCmd), rnw ? 32'd2 : 32'd1);
      check_eq({tag, "_maddr"}, bus_if.o_MAddr, {addr[31:2], 2'b00});
      check_eq({tag, "_mbe"}, 32'(bus_if.o_MByteEn), 32'(exp_be));
      if (!rnw) check_eq({tag, "_mdata"}, bus_if.o_MData, exp_mdata);
      @(posedge clk); #1;
    end
    bus_if.i_SCmdAccept = 1'b0;
    bus_if.i_SResp      = RespNull;
    if (!skip_resp) begin
      for (int n = 0; n <= nulls; n++) begin
        bus_if.i_SResp = (n == nulls) ? resp : RespNull;
        bus_if.i_SData = (n == nulls) ? sdata : 32'h5A5A_5A5A;
        @(negedge clk);
        if (lsu_busy) busy_n++;
        if (n == 0) check_eq({tag, "_mcmd_resp"}, 32'(bus_if.o_MCmd), 32'd0);
        @(posedge clk); #1;
      end
      bus_if.i_SResp = RespNull;
      bus_if.i_SData = 32'h0;
    end
    @(negedge clk);
    check_eq({tag, "_busy_end"}, 32'(lsu_busy), 32'd0);
    check_eq({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    check_eq({tag, "_ebus"}, 32'(lsu_err_bus), (!skip_resp && resp == RespErr) ? 32'd1 : 32'd0);
    check_eq({tag, "_ealign"}, 32'(lsu_err_align), 32'd0);
    check_eq({tag, "_rdata"}, lsu_rdata, exp_rdata);
  endtask

  task automatic run_misaligned(input string tag, input logic [1:0] cmd, input logic rnw,
                                input logic [31:0] addr);
    @(posedge clk); #1;
    lsu_cmd = cmd; lsu_rnw = rnw; lsu_addr = addr; lsu_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check_eq({tag, "_busy0"}, 32'(lsu_busy), 32'd0);
    @(posedge clk); #1;
    lsu_cmd = CmdIdle;
    @(negedge clk);
    check_eq({tag, "_ealign1"}, 32'(lsu_err_align), 32'd1);
    check_eq({tag, "_busy1"}, 32'(lsu_busy), 32'd0);
    check_eq({tag, "_mcmd"}, 32'(bus_if.o_MCmd), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq({tag, "_ealign2"}, 32'(lsu_err_align), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    nrst = 1'b0;
    lsu_addr = '0; lsu_wdata = '0; lsu_cmd = CmdIdle; lsu_rnw = 1'b0;
    bus_if.i_SCmdAccept = 1'b0; bus_if.i_SData = '0; bus_if.i_SResp = RespNull;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_idle_outputs("reset");
    check_eq("reset_rdata", lsu_rdata, 32'h0);
    check_eq("reset_maddr", bus_if.o_MAddr, 32'h0);
    check_eq("reset_mbe", 32'(bus_if.o_MByteEn), 32'h0);
    @(posedge clk); #1;
    nrst = 1'b1;

    // tag cmd rnw addr wdata accw nulls resp sdata be mdata rdata busy
    run_op("lw100", CmdWord, 1'b1, 32'h100, 32'h0, 0, 0, RespDva, 32'hDEAD_BEEF,
           4'b1111, 32'h0, 32'hDEAD_BEEF, 3);
    run_op("lb203", CmdByte, 1'b1, 32'h203, 32'h0, 0, 0, RespDva, 32'h1122_3344,
           4'b0001, 32'h0, 32'h0000_0044, 3);
    run_op("lh202", CmdHword, 1'b1, 32'h202, 32'h0, 0, 0, RespDva, 32'h1122_3344,
           4'b0011, 32'h0, 32'h0000_3344, 3);
    run_op("sb301", CmdByte, 1'b0, 32'h301, 32'h0000_00A5, 0, 0, RespDva, 32'h0,
           4'b0100, 32'hA5A5_A5A5, 32'h0000_3344, WrBusy);
    run_misaligned("lw102", CmdWord, 1'b1, 32'h102);
    run_misaligned("sh101", CmdHword, 1'b0, 32'h101);
    run_op("lw400err", CmdWord, 1'b1, 32'h400, 32'h0, 3, 2, RespErr, 32'hFFFF_FFFF,
           4'b1111, 32'h0, 32'h0000_3344, 8);
    run_op("sw500", CmdWord, 1'b0, 32'h500, 32'h1234_5678, 0, 0, RespDva, 32'h0,
           4'b1111, 32'h1234_5678, 32'h0000_3344, WrBusy);
    run_op("sh202", CmdHword, 1'b0, 32'h202, 32'h0000_BEEF, 1, 1, RespDva, 32'h0,
           4'b0011, 32'hBEEF_BEEF, 32'h0000_3344, Posted ? 3 : 5);
    run_op("lh200", CmdHword, 1'b1, 32'h200, 32'h0, 0, 1, RespDva, 32'h1122_3344,
           4'b1100, 32'h0, 32'h0000_1122, 4);
    run_op("lb200", CmdByte, 1'b1, 32'h200, 32'h0, 0, 0, RespDva, 32'h99AA_BBCC,
           4'b1000, 32'h0, 32'h0000_0099, 3);

    // Reset while waiting in RESP, then a late DVA must be ignored.
    @(posedge clk); #1;
    lsu_cmd = CmdWord; lsu_rnw = 1'b1; lsu_addr = 32'h600;
    @(posedge clk); #1;
    lsu_cmd = CmdIdle; bus_if.i_SCmdAccept = 1'b1;
    @(posedge clk); #1;
    bus_if.i_SCmdAccept = 1'b0;
    nrst = 1'b0;
    @(negedge clk);
    check_eq("rst_resp_busy", 32'(lsu_busy), 32'd1);
    @(posedge clk); #1;
    nrst = 1'b1;
    bus_if.i_SResp = RespDva; bus_if.i_SData = 32'hCAFE_F00D;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    check_eq("rst_mid_rdata", lsu_rdata, 32'h0);
    check_eq("rst_mid_maddr", bus_if.o_MAddr, 32'h0);
    check_eq("rst_mid_mbe", 32'(bus_if.o_MByteEn), 32'h0);
    @(posedge clk); #1;
    bus_if.i_SResp = RespNull;
    @(negedge clk);
    check_eq("late_dva_rdata", lsu_rdata, 32'h0);
    check_eq("late_dva_busy", 32'(lsu_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
